// File: rtl/pipe_pkg.sv
// Shared ISA constants for the 5-stage pipeline interlock: opcodes, field slices and FSM states.
package pipe_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_LSR  = 5'd11;
    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_NOP  = 5'd13;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    localparam logic [31:0] NOP_WORD = {OP_NOP, 27'd0};
    localparam logic [3:0]  RA_REG   = 4'd15;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 27;
    localparam int IMM_BIT = 26;
    localparam int RD_HI   = 25;
    localparam int RD_LO   = 22;
    localparam int RS1_HI  = 21;
    localparam int RS1_LO  = 18;
    localparam int RS2_HI  = 17;
    localparam int RS2_LO  = 14;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } state_e;

    function automatic logic is_mc_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/pipeline_interlock_ctrl_instr_regs_decode.sv
// Register-usage decode of one instruction word: which sources it reads and which register it writes.
module instr_regs_decode
    import pipe_pkg::*;
(
    input  logic [31:0] instr,
    output logic        reads_src1,
    output logic        reads_src2,
    output logic [3:0]  src1,
    output logic [3:0]  src2,
    output logic        writes,
    output logic [3:0]  dest
);

    logic [4:0] opc_s;
    logic       imm_s;
    logic [3:0] rd_s;
    logic       unused_imm_s;

    assign unused_imm_s = ^instr[13:0];

    // Field extraction and reader/writer classification
    always_comb begin
        opc_s      = instr[OPC_HI:OPC_LO];
        imm_s      = instr[IMM_BIT];
        rd_s       = instr[RD_HI:RD_LO];
        reads_src1 = !(opc_s inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_NOT, OP_MOV});
        writes     = !(opc_s inside {OP_NOP, OP_CMP, OP_B, OP_ST, OP_BEQ, OP_BGT, OP_RET});
        if (opc_s == OP_RET) begin
            src1 = RA_REG;
        end else begin
            src1 = instr[RS1_HI:RS1_LO];
        end
        if (opc_s == OP_CALL) begin
            dest = RA_REG;
        end else begin
            dest = rd_s;
        end
        // Stores carry their data register in the rd slot
        case (opc_s)
            OP_ST: begin
                reads_src2 = 1'b1;
                src2       = rd_s;
            end
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_AND, OP_OR,
            OP_LSL, OP_LSR, OP_ASR, OP_CMP, OP_NOT, OP_MOV: begin
                reads_src2 = !imm_s;
                src2       = instr[RS2_HI:RS2_LO];
            end
            default: begin
                reads_src2 = 1'b0;
                src2       = instr[RS2_HI:RS2_LO];
            end
        endcase
    end

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Pipeline interlock: EX/MA/RW latches, load-use and MUL/DIV stalls, branch flush and forwarding selects.
module pipeline_interlock_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_LAT      = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   of_valid,
    input  logic [31:0]            of_instr,
    output logic                   of_ready,
    input  logic                   br_taken,
    output logic                   of_flush,
    output logic [31:0]            ex_instr,
    output logic [31:0]            ma_instr,
    output logic [31:0]            rw_instr,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int MC_CNT_W = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

    state_e                 state_q, state_d;
    logic [31:0]            ex_q, ex_d, ma_q, ma_d, rw_q, rw_d;
    logic [MC_CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   rw_writes_q;
    logic [3:0]             rw_dest_q;
    logic                   of_ready_s, of_flush_s, lu_hazard_s, ma_is_ld_s;

    logic       of_rs1_s, of_rs2_s, of_wr_s, ex_rs1_s, ex_rs2_s, ex_wr_s;
    logic       ma_rs1_s, ma_rs2_s, ma_wr_s;
    logic [3:0] of_src1_s, of_src2_s, of_dest_s, ex_src1_s, ex_src2_s, ex_dest_s;
    logic [3:0] ma_src1_s, ma_src2_s, ma_dest_s;
    logic       unused_dec_s;

    instr_regs_decode u_dec_of (
        .instr(of_instr), .reads_src1(of_rs1_s), .reads_src2(of_rs2_s),
        .src1(of_src1_s), .src2(of_src2_s), .writes(of_wr_s), .dest(of_dest_s)
    );
    instr_regs_decode u_dec_ex (
        .instr(ex_q), .reads_src1(ex_rs1_s), .reads_src2(ex_rs2_s),
        .src1(ex_src1_s), .src2(ex_src2_s), .writes(ex_wr_s), .dest(ex_dest_s)
    );
    // RW always receives MA, so RW's write info is MA's decode delayed by a cycle
    instr_regs_decode u_dec_ma (
        .instr(ma_q), .reads_src1(ma_rs1_s), .reads_src2(ma_rs2_s),
        .src1(ma_src1_s), .src2(ma_src2_s), .writes(ma_wr_s), .dest(ma_dest_s)
    );

    assign unused_dec_s = ^{of_wr_s, of_dest_s, ex_wr_s, ma_rs1_s, ma_rs2_s, ma_src1_s, ma_src2_s};

    // Stage advance, stall and flush decision
    always_comb begin
        state_d     = state_q;
        ex_d        = ex_q;
        ma_d        = ma_q;
        rw_d        = ma_q;
        mc_cnt_d    = mc_cnt_q;
        of_ready_s  = 1'b0;
        of_flush_s  = 1'b0;
        lu_hazard_s = (ex_q[OPC_HI:OPC_LO] == OP_LD) && of_valid &&
                      ((of_rs1_s && (of_src1_s == ex_dest_s)) ||
                       (of_rs2_s && (of_src2_s == ex_dest_s)));
        case (state_q)
            MC_BUSY: begin
                if (mc_cnt_q == MC_CNT_W'(0)) begin
                    ma_d    = ex_q;
                    ex_d    = NOP_WORD;
                    state_d = RUN;
                end else begin
                    ma_d     = NOP_WORD;
                    mc_cnt_d = mc_cnt_q - MC_CNT_W'(1);
                end
            end
            RUN, LU_STALL: begin
                if (is_mc_op(ex_q[OPC_HI:OPC_LO])) begin
                    ma_d     = NOP_WORD;
                    mc_cnt_d = MC_CNT_W'(MC_LAT - 2);
                    state_d  = MC_BUSY;
                end else if (br_taken) begin
                    of_flush_s = 1'b1;
                    of_ready_s = 1'b1;
                    ma_d       = ex_q;
                    ex_d       = NOP_WORD;
                    state_d    = RUN;
                end else if (lu_hazard_s) begin
                    ma_d    = ex_q;
                    ex_d    = NOP_WORD;
                    state_d = LU_STALL;
                end else begin
                    of_ready_s = 1'b1;
                    ma_d       = ex_q;
                    ex_d       = of_valid ? of_instr : NOP_WORD;
                    state_d    = RUN;
                end
            end
            default: begin
                state_d  = RUN;
                ex_d     = NOP_WORD;
                ma_d     = NOP_WORD;
                mc_cnt_d = MC_CNT_W'(0);
            end
        endcase
        if (of_valid && !of_ready_s && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // EX operand forwarding: MA beats RW; a load in MA never forwards
    always_comb begin
        ma_is_ld_s = (ma_q[OPC_HI:OPC_LO] == OP_LD);
        if (ex_rs1_s && ma_wr_s && !ma_is_ld_s && (ma_dest_s == ex_src1_s)) begin
            fwd_a_sel = 2'b01;
        end else if (ex_rs1_s && rw_writes_q && (rw_dest_q == ex_src1_s)) begin
            fwd_a_sel = 2'b10;
        end else begin
            fwd_a_sel = 2'b00;
        end
        if (ex_rs2_s && ma_wr_s && !ma_is_ld_s && (ma_dest_s == ex_src2_s)) begin
            fwd_b_sel = 2'b01;
        end else if (ex_rs2_s && rw_writes_q && (rw_dest_q == ex_src2_s)) begin
            fwd_b_sel = 2'b10;
        end else begin
            fwd_b_sel = 2'b00;
        end
    end

    // Pipeline state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ex_q        <= NOP_WORD;
            ma_q        <= NOP_WORD;
            rw_q        <= NOP_WORD;
            mc_cnt_q    <= MC_CNT_W'(0);
            stall_cnt_q <= {STALL_CNT_W{1'b0}};
            rw_writes_q <= 1'b0;
            rw_dest_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            ex_q        <= ex_d;
            ma_q        <= ma_d;
            rw_q        <= rw_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            rw_writes_q <= ma_wr_s;
            rw_dest_q   <= ma_dest_s;
        end
    end

    assign of_ready  = of_ready_s & rst_n;
    assign of_flush  = of_flush_s & rst_n;
    assign ex_instr  = ex_q;
    assign ma_instr  = ma_q;
    assign rw_instr  = rw_q;
    assign stall_cnt = stall_cnt_q;

endmodule
